// File: rtl/instr_sequencer.sv
// Fetch/decode/execute/writeback sequencer for the 16-bit datapath.
// Owns pc and ir, resolves jumps/branches and counts retired instructions.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | waiting for run level or a step rising edge
//   FETCH  | pc stable, instr latched into ir at the end of the cycle
//   DECODE | opcode resolved; jumps/branches/NOPs retire here
//   EXEC   | alu_en strobe
//   WB     | wb_en strobe, ALU op retires
//   HALT   | halted until reset
module instr_sequencer #(
   parameter int PC_W  = 3,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic             step,
   input  logic [15:0]      instr,
   input  logic [2:0]       flags,
   output logic [PC_W-1:0]  pc,
   output logic [3:0]       state,
   output logic [15:0]      ir,
   output logic             alu_en,
   output logic             wb_en,
   output logic             halted,
   output logic [CNT_W-1:0] instr_count
);

   typedef enum logic [3:0] {
      S_IDLE   = 4'b0000,
      S_FETCH  = 4'b0001,
      S_DECODE = 4'b0010,
      S_EXEC   = 4'b0011,
      S_WB     = 4'b0100,
      S_HALT   = 4'b1111
   } state_t;

   state_t           st;
   logic             single;
   logic             step_q;
   logic [3:0]       opcode;
   logic [PC_W-1:0]  target;
   logic [PC_W-1:0]  pc_inc;
   logic             is_alu;
   logic             taken;
   logic             go_on;
   logic [CNT_W-1:0] count_next;
   logic             unused_carry;

   assign state        = st;
   assign opcode       = ir[15:12];
   assign target       = ir[PC_W-1:0];
   assign pc_inc       = pc + PC_W'(1);
   assign is_alu       = (opcode != 4'h0) && !opcode[3];
   assign taken        = (opcode == 4'h8) ||
                         ((opcode == 4'h9) && flags[1]) ||
                         ((opcode == 4'hA) && flags[2]);
   assign go_on        = run && !single;
   assign count_next   = (&instr_count) ? instr_count : instr_count + CNT_W'(1);
   // carry flag has no consumer among the current branch opcodes
   assign unused_carry = flags[0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st          <= S_IDLE;
         pc          <= '0;
         ir          <= '0;
         alu_en      <= 1'b0;
         wb_en       <= 1'b0;
         halted      <= 1'b0;
         instr_count <= '0;
         single      <= 1'b0;
         step_q      <= 1'b0;
      end else begin
         step_q <= step;
         alu_en <= 1'b0;
         wb_en  <= 1'b0;
         case (st)
            S_IDLE: begin
               if (run) begin
                  st     <= S_FETCH;
                  single <= 1'b0;
               end else if (step && !step_q) begin
                  st     <= S_FETCH;
                  single <= 1'b1;
               end
            end
            S_FETCH: begin
               ir <= instr;
               st <= S_DECODE;
            end
            S_DECODE: begin
               if (opcode == 4'hF) begin
                  st     <= S_HALT;
                  halted <= 1'b1;
               end else if (is_alu) begin
                  st     <= S_EXEC;
                  alu_en <= 1'b1;
               end else begin
                  pc          <= taken ? target : pc_inc;
                  instr_count <= count_next;
                  st          <= go_on ? S_FETCH : S_IDLE;
               end
            end
            S_EXEC: begin
               st    <= S_WB;
               wb_en <= 1'b1;
            end
            S_WB: begin
               pc          <= pc_inc;
               instr_count <= count_next;
               st          <= go_on ? S_FETCH : S_IDLE;
            end
            S_HALT: begin
               halted <= 1'b1;
            end
            default: begin
               st <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomized bench for instr_sequencer against an instruction-level model:
// each launched instruction expands into its list of states, effects land when it completes.
module tb_instr_sequencer;
   localparam int PC_W  = 3;
   localparam int CNT_W = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             run;
   logic             step;
   logic [15:0]      instr;
   logic [2:0]       flags;
   logic [PC_W-1:0]  pc;
   logic [3:0]       state;
   logic [15:0]      ir;
   logic             alu_en;
   logic             wb_en;
   logic             halted;
   logic [CNT_W-1:0] instr_count;

   logic [15:0] mem [8];

   int checks = 0;
   int errors = 0;

   // reference model
   int              m_state;
   logic [PC_W-1:0] m_pc;
   int              m_count;
   logic [15:0]     m_ir;
   logic [15:0]     m_word;
   bit              m_single;
   bit              m_sq;
   int              plan [$];

   bit r_lvl;
   bit s_lvl;

   instr_sequencer #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .run(run), .step(step), .instr(instr), .flags(flags),
      .pc(pc), .state(state), .ir(ir), .alu_en(alu_en), .wb_en(wb_en),
      .halted(halted), .instr_count(instr_count)
   );

   always #5 clk = ~clk;
   assign instr = mem[pc];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_pc = '0; m_count = 0; m_ir = '0; m_word = '0;
      m_single = 0; m_sq = 0;
      plan.delete();
   endtask

   task automatic model_start();
      logic [3:0] op;
      m_word  = mem[m_pc];
      op      = m_word[15:12];
      m_state = 1;
      if (op >= 4'h1 && op <= 4'h7) plan = {2, 3, 4};
      else if (op == 4'hF)          plan = {2, 15};
      else                          plan = {2};
   endtask

   // advance the model across one rising edge with the given inputs
   task automatic model_edge(input bit r, input bit s, input logic [2:0] f);
      logic [3:0] op;
      bit tk;
      if (m_state == 15) begin
      end else if (m_state == 0) begin
         if (r) begin
            m_single = 0; model_start();
         end else if (s && !m_sq) begin
            m_single = 1; model_start();
         end
      end else if (plan.size() > 0) begin
         m_state = plan.pop_front();
         if (m_state == 2) m_ir = m_word;
      end else begin
         op = m_word[15:12];
         tk = (op == 4'h8) || (op == 4'h9 && f[1]) || (op == 4'hA && f[2]);
         m_pc = tk ? m_word[PC_W-1:0] : m_pc + 1'b1;
         if (m_count < CNT_MAX) m_count++;
         if (r && !m_single) model_start();
         else m_state = 0;
      end
      m_sq = s;
   endtask

   task automatic compare_all();
      check_val("state", 32'(state), 32'(m_state));
      check_val("pc", 32'(pc), 32'(m_pc));
      check_val("ir", 32'(ir), 32'(m_ir));
      check_val("alu_en", 32'(alu_en), 32'(m_state == 3));
      check_val("wb_en", 32'(wb_en), 32'(m_state == 4));
      check_val("halted", 32'(halted), 32'(m_state == 15));
      check_val("instr_count", 32'(instr_count), 32'(m_count));
   endtask

   // mode 0 random run/step, 1 run held, 2 step held 20 cycles, 3 step toggling, 4 quiet
   task automatic drive(input int mode, input int idx);
      bit r, s;
      logic [2:0] f;
      f = 3'($urandom);
      case (mode)
         0: begin
            if ($urandom_range(0, 7) == 0) r_lvl = ~r_lvl;
            if ($urandom_range(0, 2) == 0) s_lvl = ~s_lvl;
            r = r_lvl; s = s_lvl;
         end
         1: begin r = 1; s = 0; end
         2: begin r = 0; s = (idx < 20); end
         3: begin
            if ($urandom_range(0, 2) == 0) s_lvl = ~s_lvl;
            r = 0; s = s_lvl;
         end
         default: begin r = 0; s = 0; end
      endcase
      run = r; step = s; flags = f;
      model_edge(r, s, f);
   endtask

   task automatic run_cycles(input int n, input int mode);
      for (int i = 0; i < n; i++) begin
         compare_all();
         drive(mode, i);
         @(negedge clk);
      end
   endtask

   task automatic do_reset();
      rst = 1; run = 0; step = 0; flags = '0; r_lvl = 0; s_lvl = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 0;
      model_reset();
   endtask

   task automatic random_program(input bit allow_halt);
      int k;
      for (int a = 0; a < 8; a++) begin
         k = $urandom_range(0, allow_halt ? 9 : 8);
         case (k)
            0, 1, 2, 3: mem[a] = {4'($urandom_range(1, 7)), 12'($urandom)};
            4:          mem[a] = 16'h0000;
            5, 6, 7:    mem[a] = {4'($urandom_range(8, 10)), 12'($urandom)};
            8:          mem[a] = {4'($urandom_range(11, 14)), 12'($urandom)};
            default:    mem[a] = 16'hF000;
         endcase
      end
   endtask

   initial begin
      bit found;
      rst = 1; run = 0; step = 0; flags = '0;
      for (int a = 0; a < 8; a++) mem[a] = 16'h1000;

      // free-run all-ALU, long enough to saturate the counter
      do_reset();
      run_cycles(72, 1);

      // asynchronous reset mid-EXEC at pc=5
      do_reset();
      found = 0;
      for (int i = 0; i < 80; i++) begin
         compare_all();
         if (m_state == 3 && m_pc == 3'd5) begin
            found = 1;
            break;
         end
         drive(1, i);
         @(negedge clk);
      end
      check_val("reach_exec_pc5", 32'(found), 32'd1);
      #2 rst = 1;
      #1;
      check_val("arst_state", 32'(state), 32'd0);
      check_val("arst_pc", 32'(pc), 32'd0);
      check_val("arst_ir", 32'(ir), 32'd0);
      check_val("arst_alu_en", 32'(alu_en), 32'd0);
      check_val("arst_wb_en", 32'(wb_en), 32'd0);
      check_val("arst_count", 32'(instr_count), 32'd0);
      run = 0; step = 0;
      @(negedge clk);
      rst = 0;
      model_reset();
      run_cycles(10, 4);

      // branch / jump directed program
      for (int a = 0; a < 8; a++) mem[a] = 16'h0000;
      mem[2] = 16'h9005;
      mem[5] = 16'h8006;
      mem[6] = 16'h1000;
      mem[3] = 16'hA001;
      for (int t = 0; t < 4; t++) begin
         do_reset();
         run_cycles(40, 1);
      end

      // held step and toggled step, no run
      do_reset();
      random_program(0);
      run_cycles(40, 2);
      run_cycles(80, 3);

      // halt at pc=3
      for (int a = 0; a < 8; a++) mem[a] = 16'h0000;
      mem[3] = 16'hF000;
      do_reset();
      run_cycles(20, 1);
      run_cycles(60, 0);

      // randomized programs and controls
      for (int seg = 0; seg < 30; seg++) begin
         random_program(seg % 3 == 0);
         do_reset();
         run_cycles(150, (seg % 4 == 3) ? 3 : 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
